// File: rtl/index_addr_gen_if.sv
// Bundle of index/base/control inputs and effective-address outputs for index_addr_gen.
//   master : drives index, base bytes and control strobes; observes address outputs
//   slave  : the address generator itself
interface index_addr_gen_if;
  logic [7:0]  systemBus_IN;
  logic        indexLoad_EN;
  logic [7:0]  baseLow_IN;
  logic [7:0]  baseHigh_IN;
  logic        start_EN;
  logic        zeroPage_EN;
  logic        forceFix_EN;
  logic [15:0] addr_OUT;
  logic        addrValid_OUT;
  logic        addrFinal_OUT;
  logic        pageCross_OUT;
  logic        busy_OUT;

  modport master (
    output systemBus_IN, indexLoad_EN, baseLow_IN, baseHigh_IN,
           start_EN, zeroPage_EN, forceFix_EN,
    input  addr_OUT, addrValid_OUT, addrFinal_OUT, pageCross_OUT, busy_OUT
  );

  modport slave (
    input  systemBus_IN, indexLoad_EN, baseLow_IN, baseHigh_IN,
           start_EN, zeroPage_EN, forceFix_EN,
    output addr_OUT, addrValid_OUT, addrFinal_OUT, pageCross_OUT, busy_OUT
  );
endinterface

// File: rtl/index_addr_gen.sv
// Indexed effective-address generator (base + Y index) with optional
// high-byte fix cycle on page crossing, forced fix, and zero-page mode.
// Ports:
//   clk   : system clock, rising edge
//   rst_N : asynchronous active-low reset
//   bus   : index_addr_gen_if.slave -- index load, base bytes, start/mode
//           strobes in; registered address, valid, final, page-cross, busy out
module index_addr_gen (
  input  logic               clk,
  input  logic               rst_N,
  index_addr_gen_if.slave    bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, ADD_LO, FIX_HI} state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   idx_q;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic                carry_q, carry_d;
  logic                fix_q, fix_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                final_q, final_d;
  logic                pc_q, pc_d;
  logic                busy_q, busy_d;
  logic [BYTE_W:0]     sum_c;

  // Low-byte add uses the latched index as it stands before the start edge
  assign sum_c = (BYTE_W+1)'(bus.baseLow_IN) + (BYTE_W+1)'(idx_q);

  // Index latch: loadable in any state, independent of the FSM
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      idx_q <= '0;
    end else if (bus.indexLoad_EN) begin
      idx_q <= bus.systemBus_IN;
    end
  end

  // State, operation context and output registers
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      carry_q <= 1'b0;
      fix_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      final_q <= 1'b0;
      pc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      carry_q <= carry_d;
      fix_q   <= fix_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      final_q <= final_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and next registered outputs for the state being entered
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    carry_d = carry_q;
    fix_d   = fix_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    final_d = 1'b0;
    pc_d    = pc_q;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_EN) begin
          state_d = ADD_LO;
          hi_d    = bus.zeroPage_EN ? '0 : bus.baseHigh_IN;
          lo_d    = sum_c[BYTE_W-1:0];
          carry_d = bus.zeroPage_EN ? 1'b0 : sum_c[BYTE_W];
          fix_d   = !bus.zeroPage_EN && (sum_c[BYTE_W] || bus.forceFix_EN);
          addr_d  = {hi_d, lo_d};
          valid_d = 1'b1;
          final_d = !fix_d;
          pc_d    = carry_d;
          busy_d  = 1'b1;
        end
      end
      ADD_LO: begin
        if (fix_q) begin
          // High byte wraps silently at 8'hFF
          state_d = FIX_HI;
          addr_d  = {BYTE_W'(hi_q + BYTE_W'(carry_q)), lo_q};
          valid_d = 1'b1;
          final_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FIX_HI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.addr_OUT      = addr_q;
  assign bus.addrValid_OUT = valid_q;
  assign bus.addrFinal_OUT = final_q;
  assign bus.pageCross_OUT = pc_q;
  assign bus.busy_OUT      = busy_q;

endmodule

// File: tb/tb_index_addr_gen.sv
// Scoreboard bench for index_addr_gen: driver pushes expected address beats
// from an arithmetic reference model; a monitor pops and compares on each valid beat.
module tb_index_addr_gen;

  logic clk   = 1'b0;
  logic rst_N = 1'b1;

  index_addr_gen_if bus_if ();

  index_addr_gen dut (
    .clk   (clk),
    .rst_N (rst_N),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        fin;
    logic        pc;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [15:0] last_addr = 16'h0000;
  bit          end_req   = 1'b0;
  bit          end_done  = 1'b0;

  // Reference model state (driver side)
  int m_idx    = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons live here
  initial begin
    beat_t b;
    forever begin
      @(negedge clk or negedge rst_N);
      if (!rst_N) begin
        #1;
        chk("rst_addr",  bus_if.addr_OUT, 16'h0000);
        chk("rst_valid", 16'(bus_if.addrValid_OUT), 16'd0);
        chk("rst_final", 16'(bus_if.addrFinal_OUT), 16'd0);
        chk("rst_pc",    16'(bus_if.pageCross_OUT), 16'd0);
        chk("rst_busy",  16'(bus_if.busy_OUT), 16'd0);
        exp_q.delete();
        last_addr = 16'h0000;
      end else if (end_req && !end_done) begin
        chk("drain_pending", 16'(exp_q.size()), 16'd0);
        end_done = 1'b1;
      end else if (bus_if.addrValid_OUT) begin
        chk("busy_with_valid", 16'(bus_if.busy_OUT), 16'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 16'(exp_q.size()), 16'd1);
        end else begin
          b = exp_q.pop_front();
          chk("addr",  bus_if.addr_OUT, b.addr);
          chk("final", 16'(bus_if.addrFinal_OUT), 16'(b.fin));
          chk("pcross", 16'(bus_if.pageCross_OUT), 16'(b.pc));
          last_addr = b.addr;
        end
      end else begin
        chk("idle_final", 16'(bus_if.addrFinal_OUT), 16'd0);
        chk("idle_busy",  16'(bus_if.busy_OUT), 16'd0);
        chk("idle_hold",  bus_if.addr_OUT, last_addr);
      end
    end
  end

  // Model one operation as its list of bus beats
  task automatic model_op(input bit zp, input bit ff, input logic [15:0] base);
    int    lo_sum;
    int    lo;
    int    carry;
    int    hi;
    beat_t b;
    lo_sum = int'(base[7:0]) + m_idx;
    lo     = lo_sum % 256;
    carry  = (lo_sum >= 256) ? 1 : 0;
    hi     = int'(base[15:8]);
    if (zp) begin
      b.addr = 16'(lo); b.fin = 1'b1; b.pc = 1'b0;
      exp_q.push_back(b);
      busy_cnt = 1;
    end else if (carry == 1 || ff) begin
      b.addr = 16'(hi * 256 + lo); b.fin = 1'b0; b.pc = carry[0];
      exp_q.push_back(b);
      b.addr = 16'(((hi + carry) % 256) * 256 + lo); b.fin = 1'b1;
      exp_q.push_back(b);
      busy_cnt = 2;
    end else begin
      b.addr = 16'(hi * 256 + lo); b.fin = 1'b1; b.pc = 1'b0;
      exp_q.push_back(b);
      busy_cnt = 1;
    end
  endtask

  // One clock of stimulus; model follows what the DUT samples on the edge
  task automatic cycle(input bit start, input bit zp, input bit ff,
                       input logic [15:0] base, input bit ld, input logic [7:0] val);
    @(negedge clk);
    bus_if.start_EN     = start;
    bus_if.zeroPage_EN  = zp;
    bus_if.forceFix_EN  = ff;
    bus_if.baseLow_IN   = base[7:0];
    bus_if.baseHigh_IN  = base[15:8];
    bus_if.indexLoad_EN = ld;
    bus_if.systemBus_IN = val;
    @(posedge clk);
    if (busy_cnt > 0) busy_cnt--;
    else if (start) model_op(zp, ff, base);
    if (ld) m_idx = int'(val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.start_EN     = 1'b0;
    bus_if.zeroPage_EN  = 1'b0;
    bus_if.forceFix_EN  = 1'b0;
    bus_if.baseLow_IN   = 8'h00;
    bus_if.baseHigh_IN  = 8'h00;
    bus_if.indexLoad_EN = 1'b0;
    bus_if.systemBus_IN = 8'h00;
    #1 rst_N = 1'b0;
    #20;
    @(posedge clk); #2 rst_N = 1'b1;
    idle(2);

    // Plain add, no page cross
    cycle(0, 0, 0, 16'h0000, 1, 8'h10);
    cycle(1, 0, 0, 16'h2030, 0, 8'h00);
    idle(2);
    // Page cross -> fix cycle
    cycle(0, 0, 0, 16'h0000, 1, 8'hF0);
    cycle(1, 0, 0, 16'h2030, 0, 8'h00);
    idle(3);
    // High-byte wrap
    cycle(0, 0, 0, 16'h0000, 1, 8'h01);
    cycle(1, 0, 0, 16'hFFFF, 0, 8'h00);
    idle(3);
    // Zero page wraps within page 0
    cycle(0, 0, 0, 16'h0000, 1, 8'h05);
    cycle(1, 1, 0, 16'h77FE, 0, 8'h00);
    idle(2);
    // Forced fix without carry
    cycle(0, 0, 0, 16'h0000, 1, 8'h01);
    cycle(1, 0, 1, 16'h1000, 0, 8'h00);
    idle(3);
    // Index reloaded on the start edge: op uses the old index
    cycle(1, 0, 0, 16'h4000, 1, 8'h22);
    cycle(1, 0, 0, 16'h5555, 1, 8'h33);
    idle(2);

    // Reset while in the fix cycle, starts during busy ignored
    cycle(0, 0, 0, 16'h0000, 1, 8'hF0);
    cycle(1, 0, 0, 16'h2030, 0, 8'h00);
    cycle(1, 0, 0, 16'hAAAA, 0, 8'h00);
    #2 rst_N = 1'b0;
    bus_if.start_EN = 1'b0;
    bus_if.indexLoad_EN = 1'b0;
    busy_cnt = 0;
    m_idx    = 0;
    @(negedge clk);
    @(posedge clk); #2 rst_N = 1'b1;
    cycle(1, 0, 0, 16'h1234, 0, 8'h00);
    idle(2);

    // Randomized traffic, including back-to-back and mid-operation starts
    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom % 2), ($urandom % 4) == 0, ($urandom % 4) == 0,
            16'($urandom), ($urandom % 3) == 0, 8'($urandom));
    end

    idle(4);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    if (!end_done) begin
      $display("FAIL drain: monitor never reached the end check");
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/index_addr_gen.md
INDEX_ADDR_GEN -- requirements
Module: index_addr_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port systemBus_IN, input, 8 bits: internal system bus carrying the index value driven by the Y register.
REQ-004 SHALL have port indexLoad_EN, input, 1 bit: capture systemBus_IN into the index latch on this edge.
REQ-005 SHALL have port baseLow_IN, input, 8 bits: base address low byte.
REQ-006 SHALL have port baseHigh_IN, input, 8 bits: base address high byte (ignored in zero-page mode).
REQ-007 SHALL have port start_EN, input, 1 bit: begin one effective-address computation.
REQ-008 SHALL have port zeroPage_EN, input, 1 bit: sampled with start_EN; zero-page indexed mode.
REQ-009 SHALL have port forceFix_EN, input, 1 bit: sampled with start_EN; always take the fix cycle (store/RMW).
REQ-010 SHALL have port addr_OUT, output, 16 bits: registered effective address.
REQ-011 SHALL have port addrValid_OUT, output, 1 bit: addr_OUT holds a valid bus address this cycle.
REQ-012 SHALL have port addrFinal_OUT, output, 1 bit: addr_OUT is the final, corrected address.
REQ-013 SHALL have port pageCross_OUT, output, 1 bit: low-byte add carried out for the current operation.
REQ-014 SHALL have port busy_OUT, output, 1 bit: an operation is in progress (state not IDLE).

Function
REQ-015 SHALL implement states IDLE, ADD_LO, FIX_HI; the state register and all outputs SHALL be registered.
REQ-016 SHALL update the 8-bit index latch whenever indexLoad_EN=1, in any state; a computation in flight SHALL use the index captured at its start edge.
REQ-017 SHALL, in IDLE with start_EN=1, capture base bytes, index, mode bits, and enter ADD_LO on the next edge.
REQ-018 SHALL ignore start_EN while busy_OUT=1 (no queueing, no restart).
REQ-019 SHALL, in ADD_LO, present addr_OUT={baseHigh, (baseLow+index) mod 256}, addrValid_OUT=1, pageCross_OUT=9th-bit carry of that sum.
REQ-020 SHALL, in zero-page mode, present addr_OUT={8'h00, (baseLow+index) mod 256}, pageCross_OUT=0, addrFinal_OUT=1, then return to IDLE; no fix cycle.
REQ-021 SHALL, in ADD_LO (non-zero-page), assert addrFinal_OUT=1 and return to IDLE when carry=0 and forceFix=0; otherwise addrFinal_OUT=0 and enter FIX_HI.
REQ-022 SHALL, in FIX_HI, present addr_OUT={(baseHigh+carry) mod 256, same low byte}, addrValid_OUT=1, addrFinal_OUT=1, hold pageCross_OUT, then return to IDLE.
REQ-023 SHALL wrap high byte 8'hFF+1 to 8'h00 with no further indication.
REQ-024 SHALL, in IDLE, drive addrValid_OUT=0, addrFinal_OUT=0, and hold addr_OUT and pageCross_OUT at last values.
REQ-025 SHALL give latency start-edge to final address: 1 cycle (no fix), 2 cycles (fix); addrFinal_OUT high for exactly one cycle per operation.
REQ-026 SHALL accept a new start_EN in the same cycle the FSM returns to IDLE's next cycle (back-to-back operations separated by zero idle cycles after addrFinal_OUT).

Reset
REQ-027 SHALL, on rst_N=0, immediately force state IDLE, addr_OUT=16'h0000, index latch=8'h00, addrValid_OUT=0, addrFinal_OUT=0, pageCross_OUT=0, busy_OUT=0, regardless of clock.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation with no final address; first start_EN after rst_N rises SHALL behave as from power-up.

Verification
REQ-029 SHALL pass: index 8'h10, base 16'h2030, start -> ADD_LO addr 16'h2040 final=1, pageCross=0, IDLE next cycle.
REQ-030 SHALL pass: index 8'hF0, base 16'h20 30 -> ADD_LO 16'h2020 final=0, pageCross=1; FIX_HI 16'h2120 final=1.
REQ-031 SHALL pass: index 8'h01, base 16'hFFFF -> 16'hFF00 then 16'h0000 final=1 (high-byte wrap).
REQ-032 SHALL pass: zero-page, index 8'h05, baseLow 8'hFE -> 16'h0003 final=1, pageCross=0, no FIX_HI.
REQ-033 SHALL pass: forceFix, index 8'h01, base 16'h1000 -> 16'h1001 final=0, then 16'h1001 final=1, pageCross=0.
REQ-034 SHALL pass: rst_N low during FIX_HI -> outputs zero asynchronously, no addrFinal_OUT; start_EN while busy ignored.
